// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding and
// requester identifiers used by the arbiter top and its winner picker.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between the instruction-fetch and load/store requesters.
// Default build: fixed priority, LS always beats IF.
// Define MEM_ARB_RR_EN for round-robin tie breaking; the requester that did
// not receive the most recent grant wins a tie. Only that build keeps a
// last-grant register, so only that build needs the clock and reset.
module mem_arb_pick
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic clk,
    input  logic reset,
`endif
    input  logic if_req,
    input  logic ls_req,
    input  logic accept_window,
    output logic if_gnt,
    output logic ls_gnt,
    output logic owner
);

    logic ls_wins;

`ifdef MEM_ARB_RR_EN
    logic last_grant_q;

    // Remember who was granted last; the first tie after reset goes to LS.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= REQ_IF;
        end else if (if_gnt || ls_gnt) begin
            last_grant_q <= owner;
        end
    end
`endif

    // Decide the winner and raise at most one grant inside the accept window.
    always_comb begin
        ls_wins = ls_req;
`ifdef MEM_ARB_RR_EN
        if (if_req && ls_req) begin
            ls_wins = (last_grant_q == REQ_IF);
        end
`endif
        ls_gnt = accept_window && ls_wins;
        if_gnt = accept_window && if_req && !ls_wins;
        owner  = ls_wins ? REQ_LS : REQ_IF;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port RAM between instruction fetch (IF) and
// the load/store datapath (LS). A grant in an accept window (IDLE or RESP)
// latches the request into the RAM pin registers, the access runs in ISSUE,
// and the owner's valid pulse shows up in RESP, which also accepts the next
// request, giving one access every two cycles.
// Optional build macro: MEM_ARB_RR_EN (round-robin tie breaking).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_valid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_e        state_q, state_d;
    logic              owner_q;
    logic              pick_owner;
    logic              accept_window;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_we_q;
    logic              if_valid_q, ls_valid_q;
    logic              if_valid_d, ls_valid_d;
    logic              capture_ls;
    logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;

    // Reset closes the window so nothing is granted while it is held.
    assign accept_window = !reset && (state_q == ST_IDLE || state_q == ST_RESP);

    mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
        .clk           (clk),
        .reset         (reset),
`endif
        .if_req        (if_req),
        .ls_req        (ls_req),
        .accept_window (accept_window),
        .if_gnt        (if_gnt),
        .ls_gnt        (ls_gnt),
        .owner         (pick_owner)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: any grant starts an access, ISSUE always moves on to RESP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_RESP: state_d = (if_gnt || ls_gnt) ? ST_ISSUE : ST_IDLE;
            ST_ISSUE:         state_d = ST_RESP;
            default:          state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: the RAM returns data during ISSUE (one cycle after the
    // address register was loaded), so it is captured at the ISSUE->RESP edge
    // and the owner's valid is visible throughout RESP. mem_we_q is high in
    // ISSUE exactly for an LS write, so it doubles as the write flag there.
    always_comb begin
        busy       = (state_q != ST_IDLE);
        if_valid_d = (state_q == ST_ISSUE) && (owner_q == REQ_IF);
        ls_valid_d = (state_q == ST_ISSUE) && (owner_q == REQ_LS);
        capture_ls = ls_valid_d && !mem_we_q;
    end

    // RAM pin registers, owner tracking, valid pulses and read-data holding.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q     <= REQ_IF;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            if_valid_q  <= 1'b0;
            ls_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            mem_we_q   <= 1'b0;
            if_valid_q <= if_valid_d;
            ls_valid_q <= ls_valid_d;
            if (if_valid_d) begin
                if_rdata_q <= mem_rdata;
            end
            if (capture_ls) begin
                ls_rdata_q <= mem_rdata;
            end
            if (if_gnt || ls_gnt) begin
                owner_q <= pick_owner;
                if (ls_gnt) begin
                    mem_addr_q  <= ls_addr;
                    mem_wdata_q <= ls_wdata;
                    mem_we_q    <= ls_we;
                end else begin
                    mem_addr_q  <= if_addr;
                end
            end
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign if_valid  = if_valid_q;
    assign ls_valid  = ls_valid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter. Expected grants come from a
// small arbitration model, expected responses are queued at grant time and
// retired when the valid pulse is due. Honours MEM_ARB_RR_EN like the design.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt, if_valid;
    logic [15:0] if_rdata;
    logic        ls_req, ls_we;
    logic [15:0] ls_addr, ls_wdata;
    logic        ls_gnt, ls_valid;
    logic [15:0] ls_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic        busy;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_valid  (ls_valid),
        .ls_rdata  (ls_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Power-up contents of an untouched RAM word.
    function automatic logic [15:0] initWord(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hA5C3 : (a ^ 16'h5A5A);
    endfunction

    // RAM model: writes on the clock, read data follows the address register.
    bit [15:0] ram   [0:1023];
    bit        wrote [0:1023];
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr[9:0]]   <= mem_wdata;
            wrote[mem_addr[9:0]] <= 1'b1;
        end
    end
    assign mem_rdata = wrote[mem_addr[9:0]] ? ram[mem_addr[9:0]] : initWord(mem_addr);

    // Bench-side memory image used to predict read data.
    bit [15:0] shadow      [0:1023];
    bit        shadowWrote [0:1023];

    function automatic logic [15:0] shadowRead(input logic [15:0] a);
        return shadowWrote[a[9:0]] ? shadow[a[9:0]] : initWord(a);
    endfunction

    typedef struct {
        logic        who;
        logic        wr;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic        actLog[$];
    int          vectors   = 0;
    int          miscompares = 0;
    int          cyc       = 0;
    int          winCyc    = 0;
    int          grantCyc  = -10;
    logic        grantWr   = 1'b0;
    logic [15:0] grantAddr = '0;
    logic [15:0] grantData = '0;
    logic        lastModel = 1'b0;
    logic [15:0] ifHeld    = '0;
    logic [15:0] lsHeld    = '0;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's requests, then check the grants against the model.
    task automatic applyStimulus(input logic ir, input logic [15:0] ia, input logic lr,
                                 input logic lw, input logic [15:0] la, input logic [15:0] lwd);
        logic window, expIf, expLs;
        exp_t e;
        if_req = ir; if_addr = ia;
        ls_req = lr; ls_we = lw; ls_addr = la; ls_wdata = lwd;
        #1;
        if (reset) begin
            winCyc    = 0;
            lastModel = 1'b0;
        end
        window = !reset && (cyc >= winCyc);
        expLs  = window && lr;
        if (window && lr && ir) begin
`ifdef MEM_ARB_RR_EN
            expLs = (lastModel == 1'b0);
`else
            expLs = 1'b1;
`endif
        end
        expIf = window && ir && !expLs;
        checkOutput("if_gnt", 16'(if_gnt), 16'(expIf));
        checkOutput("ls_gnt", 16'(ls_gnt), 16'(expLs));
        if (if_gnt || ls_gnt) actLog.push_back(ls_gnt);
        if (expIf || expLs) begin
            lastModel = expLs;
            winCyc    = cyc + 2;
            grantCyc  = cyc;
            grantWr   = expLs && lw;
            grantAddr = expLs ? la : ia;
            grantData = lwd;
            e.who = expLs;
            e.wr  = expLs && lw;
            e.due = cyc + 2;
            e.data = expLs ? (lw ? 16'h0000 : shadowRead(la)) : shadowRead(ia);
            if (e.wr) begin
                shadow[la[9:0]]      = lwd;
                shadowWrote[la[9:0]] = 1'b1;
            end
            sb.push_back(e);
        end
    endtask

    // Advance one clock and check registered outputs against the scoreboard.
    task automatic stepCycle();
        logic expIfV, expLsV;
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (reset) begin
            sb.delete();
            ifHeld   = '0;
            lsHeld   = '0;
            grantCyc = -10;
        end
        expIfV = 1'b0;
        expLsV = 1'b0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if (e.who) begin
                expLsV = 1'b1;
                if (!e.wr) lsHeld = e.data;
            end else begin
                expIfV = 1'b1;
                ifHeld = e.data;
            end
        end
        checkOutput("if_valid", 16'(if_valid), 16'(expIfV));
        checkOutput("ls_valid", 16'(ls_valid), 16'(expLsV));
        checkOutput("if_rdata", if_rdata, ifHeld);
        checkOutput("ls_rdata", ls_rdata, lsHeld);
        checkOutput("busy", 16'(busy), 16'((cyc == grantCyc + 1) || (cyc == grantCyc + 2)));
        checkOutput("mem_we", 16'(mem_we), 16'((cyc == grantCyc + 1) && grantWr));
        if (cyc == grantCyc + 1) begin
            checkOutput("mem_addr", mem_addr, grantAddr);
            if (grantWr) checkOutput("mem_wdata", mem_wdata, grantData);
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
            stepCycle();
        end
    endtask

    initial begin
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;

        // Reset held two cycles with both requesters asking.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0200, 16'h0);
            stepCycle();
        end
        reset = 1'b0;
        idleCycles(1);

        // IF read of the preloaded word.
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0);
        stepCycle();
        idleCycles(3);

        // LS write followed by LS read of the same word.
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'h0200, 16'h1234);
        stepCycle();
        idleCycles(2);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0200, 16'h0);
        stepCycle();
        idleCycles(2);

        // IF read so that the most recent grant before contention is IF.
        applyStimulus(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0, 16'h0);
        stepCycle();
        idleCycles(2);

        // Contention: both requesters held continuously.
        actLog.delete();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0200, 16'h0);
            stepCycle();
        end
        checkOutput("cont_count", 16'(actLog.size()), 16'd3);
        if (actLog.size() == 3) begin
            checkOutput("cont_g0", 16'(actLog[0]), 16'd1);
`ifdef MEM_ARB_RR_EN
            checkOutput("cont_g1", 16'(actLog[1]), 16'd0);
`else
            checkOutput("cont_g1", 16'(actLog[1]), 16'd1);
`endif
            checkOutput("cont_g2", 16'(actLog[2]), 16'd1);
        end
        idleCycles(2);

        // Back-to-back: new LS request presented in the RESP cycle.
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0010, 16'h0);
        stepCycle();
        idleCycles(1);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0200, 16'h0);
        checkOutput("b2b_valid", 16'(ls_valid), 16'd1);
        checkOutput("b2b_gnt", 16'(ls_gnt), 16'd1);
        stepCycle();
        idleCycles(3);

        // Reset asserted while an LS write is in ISSUE.
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'h0300, 16'hBEEF);
        stepCycle();
        checkOutput("rst_issue_we", 16'(mem_we), 16'd1);
        reset = 1'b1;
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        stepCycle();
        checkOutput("rst_we_after", 16'(mem_we), 16'd0);
        checkOutput("rst_busy_after", 16'(busy), 16'd0);
        reset = 1'b0;
        idleCycles(3);

        checkOutput("sb_drain", 16'(sb.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
